// File: rtl/vga_timing_gen.sv
// Purpose: VGA raster timing generator: pixel divider, h/v counters, pixel requests, registered colour and syncs.
// Latency: one pixel period from a pixel request (pixelX/pixelY/pixelReq) to the matching colour and sync outputs.
// Backpressure: none; free-running raster, the colour source must present data within each pixel period.
`timescale 1ns/1ps
module vga_timing_gen #(
    parameter int CLK_DIV    = 2,
    parameter int COLOR_BITS = 4,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [COLOR_BITS-1:0] pixelRed,
    input  logic [COLOR_BITS-1:0] pixelGreen,
    input  logic [COLOR_BITS-1:0] pixelBlue,
    output logic [10:0]           pixelX,
    output logic [10:0]           pixelY,
    output logic                  pixelReq,
    output logic                  pixelTick,
    output logic [COLOR_BITS-1:0] vgaRed,
    output logic [COLOR_BITS-1:0] vgaGreen,
    output logic [COLOR_BITS-1:0] vgaBlue,
    output logic                  hSync,
    output logic                  vSync,
    output logic                  frameStart
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [10:0]      H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0]      V_LAST   = 11'(V_TOTAL - 1);

    // Region boundaries are compared at 12 bits so that a sync region ending
    // exactly at 2048 (zero-length back porch, maximal total) still compares correctly.
    localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE);
    localparam logic [11:0] H_SYNC_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] V_ACT_END  = 12'(V_ACTIVE);
    localparam logic [11:0] V_SYNC_BEG = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_cnt;
    logic [10:0]      h_cnt;
    logic [10:0]      v_cnt;
    logic [11:0]      h_ext;
    logic [11:0]      v_ext;
    logic             tick;
    logic             h_active;
    logic             v_active;
    logic             h_in_sync;
    logic             v_in_sync;
    logic             h_wrap;
    logic             v_wrap;

    // Pixel-rate divider: counts system clocks within one pixel period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Raster position decode; the tick is gated by reset so it is silent while held
    // in reset even when every clock is a pixel (CLK_DIV = 1).
    always_comb begin
        tick      = !rst && (div_cnt == DIV_LAST);
        h_ext     = {1'b0, h_cnt};
        v_ext     = {1'b0, v_cnt};
        h_active  = (h_ext < H_ACT_END);
        v_active  = (v_ext < V_ACT_END);
        h_in_sync = (h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END);
        v_in_sync = (v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END);
        h_wrap    = (h_cnt == H_LAST);
        v_wrap    = (v_cnt == V_LAST);
    end

    // Horizontal and vertical counters advance once per pixel; the line counter
    // steps on the tick where the pixel counter wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (tick) begin
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_wrap ? 11'd0 : v_cnt + 11'd1;
            end else begin
                h_cnt <= h_cnt + 11'd1;
            end
        end
    end

    // Request side: coordinates are forced to zero outside the visible area.
    always_comb begin
        pixelReq   = h_active && v_active;
        pixelX     = pixelReq ? h_cnt : 11'd0;
        pixelY     = pixelReq ? v_cnt : 11'd0;
        pixelTick  = tick;
        frameStart = tick && (h_cnt == 11'd0) && (v_cnt == 11'd0);
    end

    // Output stage: capture colour and syncs for the pixel being requested now,
    // so the DAC sees them one pixel period later; blanking overrides the inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vgaRed   <= '0;
            vgaGreen <= '0;
            vgaBlue  <= '0;
            hSync    <= ~H_SYNC_POL;
            vSync    <= ~V_SYNC_POL;
        end else if (tick) begin
            vgaRed   <= pixelReq ? pixelRed   : '0;
            vgaGreen <= pixelReq ? pixelGreen : '0;
            vgaBlue  <= pixelReq ? pixelBlue  : '0;
            hSync    <= h_in_sync ? H_SYNC_POL : ~H_SYNC_POL;
            vSync    <= v_in_sync ? V_SYNC_POL : ~V_SYNC_POL;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen with a small raster (CLK_DIV=3, 13x7 totals, zero-length porches).
// Expected outputs are derived from the clock count since reset release.
// Colours change randomly once per pixel period; a mid-line reset is applied during hsync.
`timescale 1ns/1ps
module tb_vga_timing_gen;

    localparam int D  = 3;
    localparam int CB = 4;
    localparam int HA = 8, HF = 2, HS = 3, HB = 0;
    localparam int VA = 4, VF = 0, VS = 2, VB = 1;
    localparam bit HP = 1'b0;
    localparam bit VP = 1'b1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CB-1:0] r = '0, g = '0, b = '0;
    logic [10:0]   pixelX, pixelY;
    logic          pixelReq, pixelTick, hSync, vSync, frameStart;
    logic [CB-1:0] vgaRed, vgaGreen, vgaBlue;

    int errors = 0;
    int checks = 0;

    vga_timing_gen #(
        .CLK_DIV(D), .COLOR_BITS(CB),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_SYNC_POL(HP), .V_SYNC_POL(VP)
    ) dut (
        .clk(clk), .rst(rst),
        .pixelRed(r), .pixelGreen(g), .pixelBlue(b),
        .pixelX(pixelX), .pixelY(pixelY), .pixelReq(pixelReq), .pixelTick(pixelTick),
        .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue),
        .hSync(hSync), .vSync(vSync), .frameStart(frameStart)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    // Model state: clocks since reset release, and the colour present at the last pixel tick.
    int            n;
    logic [CB-1:0] cap_r, cap_g, cap_b;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n <= 0;
        end else begin
            if (n % D == D - 1) begin
                cap_r <= r;
                cap_g <= g;
                cap_b <= b;
            end
            n <= n + 1;
        end
    end

    // Every-cycle comparison against the arithmetic raster model.
    int p, h, v, q, hq, vq;
    bit e_tick, e_req, e_act;
    always @(negedge clk) begin
        p      = n / D;
        h      = p % HT;
        v      = (p / HT) % VT;
        e_tick = !rst && (n % D == D - 1);
        e_req  = (h < HA) && (v < VA);
        chk("pixelTick", pixelTick, e_tick);
        chk("pixelReq", pixelReq, e_req);
        chk("pixelX", pixelX, e_req ? h : 0);
        chk("pixelY", pixelY, e_req ? v : 0);
        chk("frameStart", frameStart, e_tick && h == 0 && v == 0);
        if (!rst && n >= D) begin
            q     = p - 1;
            hq    = q % HT;
            vq    = (q / HT) % VT;
            e_act = (hq < HA) && (vq < VA);
            chk("hSync", hSync, (hq >= HA + HF && hq < HA + HF + HS) ? HP : !HP);
            chk("vSync", vSync, (vq >= VA + VF && vq < VA + VF + VS) ? VP : !VP);
            chk("vgaRed", vgaRed, e_act ? cap_r : 0);
            chk("vgaGreen", vgaGreen, e_act ? cap_g : 0);
            chk("vgaBlue", vgaBlue, e_act ? cap_b : 0);
        end else begin
            chk("hSync_idle", hSync, !HP);
            chk("vSync_idle", vSync, !VP);
            chk("colour_idle", {vgaRed, vgaGreen, vgaBlue}, 0);
        end
    end

    // Event timing monitor feeding the literal checks at the end.
    int phase = 0;
    int hs_fall[2] = '{-1, -1};
    int fs_first[2] = '{-1, -1};
    int fs_second = -1;
    int vs_rise = -1, vs_fall = -1;
    logic prev_hs = 1'b1, prev_vs = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_hs === 1'b1 && hSync === 1'b0 && hs_fall[phase] < 0) hs_fall[phase] = n;
            if (phase == 0 && prev_vs === 1'b0 && vSync === 1'b1 && vs_rise < 0) vs_rise = n;
            if (phase == 0 && prev_vs === 1'b1 && vSync === 1'b0 && vs_fall < 0) vs_fall = n;
            if (frameStart === 1'b1) begin
                if (fs_first[phase] < 0) fs_first[phase] = n;
                else if (phase == 0 && fs_second < 0) fs_second = n;
            end
        end
        prev_hs = hSync;
        prev_vs = vSync;
    end

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            #2;
            if (n % D == 0) begin
                r = CB'($urandom_range(15, 0));
                g = CB'($urandom_range(15, 0));
                b = CB'($urandom_range(15, 0));
            end
        end
    endtask

    bit found;
    initial begin
        repeat (3) @(negedge clk);
        chk("rst_hSync", hSync, 1);
        chk("rst_vSync", vSync, 0);
        chk("rst_tick", pixelTick, 0);
        #2 rst = 1'b0;
        run(3 * D * HT * VT);

        // Reset while hsync is asserted on line 2 of the visible area.
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            run(1);
            if (n >= D && ((n / D) - 1) % HT == HA + HF + 1 && (((n / D) - 1) / HT) % VT == 2)
                found = 1'b1;
        end
        chk("rst_point_found", found, 1);
        chk("pre_rst_hSync", hSync, 0);
        rst = 1'b1;
        #1;
        chk("async_hSync", hSync, 1);
        chk("async_vSync", vSync, 0);
        chk("async_colour", {vgaRed, vgaGreen, vgaBlue}, 0);
        chk("async_tick", pixelTick, 0);
        chk("async_pixelY", pixelY, 0);
        repeat (2) @(negedge clk);
        #2;
        phase = 1;
        rst   = 1'b0;
        run(2 * D * HT * VT);

        // Hand-computed timing: hsync at pixel 10 -> 11th tick -> clk 33;
        // vsync at line 4 -> pixel 52 -> clk 159, lasts 2 lines = 78 clks; frame = 273 clks.
        chk("hs_first_fall", hs_fall[0], 33);
        chk("hs_fall_after_rst", hs_fall[1], 33);
        chk("vs_first_rise", vs_rise, 159);
        chk("vs_width", vs_fall - vs_rise, 78);
        chk("fs_first", fs_first[0], 2);
        chk("fs_period", fs_second - fs_first[0], 273);
        chk("fs_after_rst", fs_first[1], 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
